normalize32_seq: RTL and testbench
==================================

# normalize32_seq

Multi-cycle normalizer for the FPU754 add/sub and int-to-float paths. It accepts an unnormalized 32-bit mantissa and a biased exponent, then left-shifts the mantissa until its MSB is set. Each cycle it takes a coarse 7-bit step or a fine 1-bit step, decrementing the exponent to match. It stops early on a zero mantissa or when the exponent reaches 1, which is the denormal boundary. Valid/ready handshakes on both sides; it sits between the mantissa adder and the rounding stage.

## Interface
- EXP_W, 8, biased exponent width (unsigned)
- BIG_STEP, 7, coarse shift distance in bits (fixed at 7; parameter for documentation only)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand this cycle
- in_mant  in  32  unnormalized mantissa
- in_exp  in  EXP_W  biased exponent of in_mant
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accepts result
- out_mant  out  32  normalized mantissa
- out_exp  out  EXP_W  adjusted exponent
- out_shift  out  5  total left-shift applied (0..31)
- out_zero  out  1  input mantissa was zero
- out_denorm  out  1  stopped at exponent 1 with MSB still clear

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset state is IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (in_valid & in_ready):
  - Load the mant/exp working registers.
  - Clear the shift counter.
  - Go to SHIFT.
- SHIFT performs one evaluation per cycle. Conditions are checked in priority order:
  1. mant==0: go to DONE with out_zero=1, out_exp=0, out_shift=0, out_mant=0.
  2. mant[31]==1: go to DONE with the current mant, exp and count.
  3. mant[31:25]==0 and exp>7: shift mant left 7 with zero fill, exp-=7, count+=7. Stay in SHIFT.
  4. exp>1: shift mant left 1, exp-=1, count+=1. Stay in SHIFT.
  5. Otherwise (exp<=1): go to DONE with out_denorm=1 and the current mant, exp and count.
- An input with in_exp of 0 takes rule 5 immediately unless rule 1 or 2 applies. The output exponent is then 0, unchanged.
- DONE: outputs are registered and stable while out_valid & !out_ready.
  - out_ready & !in_valid: go to IDLE.
  - out_ready & in_valid: accept the new operand and go to SHIFT in the same edge (back-to-back).
- Arithmetic is unsigned. The exponent never underflows, because rules 3 and 4 guard it. out_shift never exceeds 31.
- in_valid in SHIFT is ignored (in_ready=0); the operand must be held by the source.

## Timing
- Latency from the accept edge to out_valid high is 1 + S edges, where S is the number of shift steps taken.
  - MSB already set: 1 edge.
  - Worst case, mant=1 with a large exponent: 4 coarse + 3 fine steps, so 8 edges.
- Throughput is one result per (1 + S) cycles with back-to-back acceptance; there is no bubble in DONE when out_ready is high.
- Reset values: out_valid=0, in_ready=0 while rst is asserted, then 1 in IDLE. out_mant=0, out_exp=0, out_shift=0, out_zero=0, out_denorm=0.
- Reset mid-operation asynchronously returns the block to IDLE. The in-flight operand is discarded and no output is produced.

## Structure
- Shared package/header fpu754_defs holds:
  - FSM state encodings (S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2)
  - BIG_STEP=7
  - the default exponent width
- One combinational sub-module, normalize32_step, is natural. It takes mant and exp and returns next mant, next exp, step size (0/1/7) and a terminate code (none/zero/norm/denorm). The FSM and registers stay in normalize32_seq.

## Test plan
- in_mant=0x80000000, in_exp=100 -> out_valid after 1 edge; out_mant=0x80000000, out_exp=100, out_shift=0, flags 0.
- in_mant=0x00000001, in_exp=200 -> out_valid after 8 edges; out_mant=0x80000000, out_exp=169, out_shift=31.
- in_mant=0x00000001, in_exp=5 -> 4 fine steps, out_valid after 5 edges; out_mant=0x00000010, out_exp=1, out_shift=4, out_denorm=1.
- in_mant=0, in_exp=77 -> out_valid after 1 edge; out_zero=1, out_exp=0, out_mant=0, out_shift=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0.
  - Then raise out_ready with in_valid=1 (0x00800000, exp 50) -> same-edge accept, next result out_mant=0x80000000, out_exp=42, out_shift=8 after 3 edges.
- Assert rst during SHIFT (mant=1, exp=200, at edge 3) -> all outputs 0, state IDLE. After release, a fresh operand completes normally.

Source files
------------

// File: rtl/fpu754_defs.sv
// rtl/fpu754_defs.sv - shared FPU754 normalizer definitions
package fpu754_defs;

    localparam int FPU_EXP_W    = 8;
    localparam int FPU_BIG_STEP = 7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        T_NONE   = 2'd0,
        T_ZERO   = 2'd1,
        T_NORM   = 2'd2,
        T_DENORM = 2'd3
    } term_e;

endpackage

// File: rtl/normalize32_step.sv
// rtl/normalize32_step.sv - one normalization evaluation (coarse, fine or terminate)
module normalize32_step
    import fpu754_defs::*;
#(
    parameter int EXP_W    = FPU_EXP_W,
    parameter int BIG_STEP = FPU_BIG_STEP
) (
    input  logic [31:0]      mant_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [31:0]      mant_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [2:0]       step_o,
    output term_e            term_o
);

    // Priority: zero, already normalized, coarse step, fine step, denormal stop.
    // The exponent guards keep the working exponent from ever dropping below 1.
    always_comb begin
        mant_o = mant_i;
        exp_o  = exp_i;
        step_o = 3'd0;
        term_o = T_NONE;
        if (mant_i == '0) begin
            term_o = T_ZERO;
        end else if (mant_i[31]) begin
            term_o = T_NORM;
        end else if ((mant_i[31 -: BIG_STEP] == '0) && (exp_i > EXP_W'(BIG_STEP))) begin
            mant_o = mant_i << BIG_STEP;
            exp_o  = exp_i - EXP_W'(BIG_STEP);
            step_o = 3'(BIG_STEP);
        end else if (exp_i > EXP_W'(1)) begin
            mant_o = mant_i << 1;
            exp_o  = exp_i - EXP_W'(1);
            step_o = 3'd1;
        end else begin
            term_o = T_DENORM;
        end
    end

endmodule

// File: rtl/normalize32_seq.sv
// rtl/normalize32_seq.sv - multi-cycle 32-bit mantissa normalizer with handshakes
module normalize32_seq
    import fpu754_defs::*;
#(
    parameter int EXP_W    = FPU_EXP_W,
    parameter int BIG_STEP = FPU_BIG_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [4:0]       out_shift,
    output logic             out_zero,
    output logic             out_denorm
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      mant_q, mant_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [31:0]      o_mant_q, o_mant_d;
    logic [EXP_W-1:0] o_exp_q, o_exp_d;
    logic [4:0]       o_shift_q, o_shift_d;
    logic             o_zero_q, o_zero_d;
    logic             o_denorm_q, o_denorm_d;

    logic [31:0]      step_mant;
    logic [EXP_W-1:0] step_exp;
    logic [2:0]       step_size;
    term_e            step_term;
    logic             accept;

    normalize32_step #(
        .EXP_W    (EXP_W),
        .BIG_STEP (BIG_STEP)
    ) u_step (
        .mant_i (mant_q),
        .exp_i  (exp_q),
        .mant_o (step_mant),
        .exp_o  (step_exp),
        .step_o (step_size),
        .term_o (step_term)
    );

    assign in_ready   = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == S_DONE);
    assign out_mant   = o_mant_q;
    assign out_exp    = o_exp_q;
    assign out_shift  = o_shift_q;
    assign out_zero   = o_zero_q;
    assign out_denorm = o_denorm_q;

    // Next-state: load on accept (including back-to-back from DONE), step while shifting,
    // latch result registers on the terminating evaluation.
    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        o_mant_d   = o_mant_q;
        o_exp_d    = o_exp_q;
        o_shift_d  = o_shift_q;
        o_zero_d   = o_zero_q;
        o_denorm_d = o_denorm_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mant_d  = in_mant;
                    exp_d   = in_exp;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                case (step_term)
                    T_NONE: begin
                        mant_d = step_mant;
                        exp_d  = step_exp;
                        cnt_d  = cnt_q + {2'b00, step_size};
                    end
                    T_ZERO: begin
                        state_d    = S_DONE;
                        o_mant_d   = '0;
                        o_exp_d    = '0;
                        o_shift_d  = '0;
                        o_zero_d   = 1'b1;
                        o_denorm_d = 1'b0;
                    end
                    default: begin
                        state_d    = S_DONE;
                        o_mant_d   = mant_q;
                        o_exp_d    = exp_q;
                        o_shift_d  = cnt_q;
                        o_zero_d   = 1'b0;
                        o_denorm_d = (step_term == T_DENORM);
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mant_q     <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            o_mant_q   <= '0;
            o_exp_q    <= '0;
            o_shift_q  <= '0;
            o_zero_q   <= 1'b0;
            o_denorm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            o_mant_q   <= o_mant_d;
            o_exp_q    <= o_exp_d;
            o_shift_q  <= o_shift_d;
            o_zero_q   <= o_zero_d;
            o_denorm_q <= o_denorm_d;
        end
    end

endmodule

// File: tb/tb_normalize32_seq.sv
// tb/tb_normalize32_seq.sv - self-checking bench for normalize32_seq
module tb_normalize32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_shift;
    logic        out_zero;
    logic        out_denorm;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  exp;
        logic [4:0]  shift;
        logic        zero;
        logic        denorm;
        int          edges;
    } res_t;

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  exp;
        res_t        want;
    } vec_t;

    vec_t vecs[$];

    normalize32_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_shift  (out_shift),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference: shift by the leading-zero count, limited so the exponent stops at 1.
    // Latency counts coarse 7-bit steps plus leftover single-bit steps.
    function automatic res_t model(input logic [31:0] m, input logic [7:0] e);
        res_t r;
        int lz, sh;
        r.mant = '0; r.exp = '0; r.shift = '0; r.zero = 1'b0; r.denorm = 1'b0; r.edges = 1;
        if (m == 32'd0) begin
            r.zero = 1'b1;
            return r;
        end
        lz = 0;
        while (m[31-lz] == 1'b0) lz++;
        sh = (e == 8'd0) ? 0 : ((lz < int'(e) - 1) ? lz : int'(e) - 1);
        r.mant   = m << sh;
        r.exp    = e - 8'(sh);
        r.shift  = 5'(sh);
        r.denorm = (sh < lz);
        r.edges  = 1 + sh / 7 + sh % 7;
        return r;
    endfunction

    task automatic add_vec(input logic [31:0] m, input logic [7:0] e, input logic [31:0] rm,
                           input logic [7:0] re, input logic [4:0] rs, input logic z,
                           input logic d, input int ed);
        vec_t v;
        v.mant = m; v.exp = e;
        v.want.mant = rm; v.want.exp = re; v.want.shift = rs;
        v.want.zero = z; v.want.denorm = d; v.want.edges = ed;
        vecs.push_back(v);
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic capture(inout res_t r);
        r.mant = out_mant; r.exp = out_exp; r.shift = out_shift;
        r.zero = out_zero; r.denorm = out_denorm;
    endtask

    task automatic cmp_res(input string tag, input res_t got, input res_t want);
        check({tag, ".mant"},   64'(got.mant),   64'(want.mant));
        check({tag, ".exp"},    64'(got.exp),    64'(want.exp));
        check({tag, ".shift"},  64'(got.shift),  64'(want.shift));
        check({tag, ".zero"},   64'(got.zero),   64'(want.zero));
        check({tag, ".denorm"}, 64'(got.denorm), 64'(want.denorm));
        check({tag, ".edges"},  64'(got.edges),  64'(want.edges));
    endtask

    // Called #1 after a rising edge with the DUT idle; leaves it idle.
    task automatic run_op(input logic [31:0] m, input logic [7:0] e, output res_t r);
        int n;
        in_mant = m; in_exp = e; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(n);
        r.edges = n;
        capture(r);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        res_t got, want, held;
        int n;

        add_vec(32'h8000_0000, 8'd100, 32'h8000_0000, 8'd100, 5'd0,  1'b0, 1'b0, 1);
        add_vec(32'h0000_0001, 8'd200, 32'h8000_0000, 8'd169, 5'd31, 1'b0, 1'b0, 8);
        add_vec(32'h0000_0001, 8'd5,   32'h0000_0010, 8'd1,   5'd4,  1'b0, 1'b1, 5);
        add_vec(32'h0000_0000, 8'd77,  32'h0000_0000, 8'd0,   5'd0,  1'b1, 1'b0, 1);
        add_vec(32'h0000_0010, 8'd0,   32'h0000_0010, 8'd0,   5'd0,  1'b0, 1'b1, 1);
        add_vec(32'hFFFF_FFFF, 8'd0,   32'hFFFF_FFFF, 8'd0,   5'd0,  1'b0, 1'b0, 1);
        add_vec(32'h4000_0000, 8'd1,   32'h4000_0000, 8'd1,   5'd0,  1'b0, 1'b1, 1);
        add_vec(32'h4000_0000, 8'd2,   32'h8000_0000, 8'd1,   5'd1,  1'b0, 1'b0, 2);
        add_vec(32'h0000_0001, 8'd8,   32'h0000_0080, 8'd1,   5'd7,  1'b0, 1'b1, 2);
        add_vec(32'h0000_0001, 8'd7,   32'h0000_0040, 8'd1,   5'd6,  1'b0, 1'b1, 7);
        add_vec(32'h0080_0000, 8'd50,  32'h8000_0000, 8'd42,  5'd8,  1'b0, 1'b0, 3);
        add_vec(32'h0000_0000, 8'd0,   32'h0000_0000, 8'd0,   5'd0,  1'b1, 1'b0, 1);

        // Reset state while rst is held
        @(posedge clk); #1;
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.outputs",   64'({out_mant, out_exp, out_shift, out_zero, out_denorm}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("idle.in_ready", 64'(in_ready), 64'd1);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].mant, vecs[i].exp, got);
            cmp_res($sformatf("vec%0d", i), got, vecs[i].want);
        end

        // Backpressure hold, then same-edge accept from DONE
        in_mant = 32'h8000_0000; in_exp = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(n);
        check("bp.first_edges", 64'(n), 64'd1);
        held = model(32'h8000_0000, 8'd100);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.hold_ready", 64'(in_ready),  64'd0);
            check("bp.hold_data",  64'({out_mant, out_exp, out_shift}),
                  64'({held.mant, held.exp, held.shift}));
        end
        in_mant = 32'h0080_0000; in_exp = 8'd50; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp.accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp.shifting", 64'(out_valid), 64'd0);
        wait_result(n);
        got.edges = n;
        capture(got);
        cmp_res("bp.second", got, vecs[10].want);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a long shift
        in_mant = 32'h0000_0001; in_exp = 8'd200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid.still_busy", 64'(out_valid), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("mid.rst_valid",   64'(out_valid), 64'd0);
        check("mid.rst_ready",   64'(in_ready),  64'd0);
        check("mid.rst_outputs", 64'({out_mant, out_exp, out_shift, out_zero, out_denorm}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid.idle_ready", 64'(in_ready),  64'd1);
        check("mid.idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        run_op(32'h0000_0001, 8'd200, got);
        cmp_res("mid.fresh", got, vecs[1].want);

        // Randomized against the reference model
        for (int k = 0; k < 200; k++) begin
            logic [31:0] m;
            logic [7:0]  e;
            m = $urandom >> $urandom_range(0, 32);
            e = 8'($urandom_range(0, 255));
            want = model(m, e);
            run_op(m, e, got);
            cmp_res($sformatf("rnd%0d_m%08h_e%0d", k, m, e), got, want);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
